// File: rtl/lut_neuron_cfg_loader.sv
// Runtime-loadable truth-table neuron: streams a table in over cfg_*,
// then serves registered lookups table[in_data] on in_*/out_*.
//   clk, rst           : clock, async active-high reset
//   cfg_start          : pulse, begin (re)load of the whole table
//   cfg_valid/cfg_data : config beat; cfg_ready high only while loading
//   cfg_done, cfg_err  : pulses, last beat taken / restart during load
//   table_ready        : table armed, lookups served
//   in_valid/in_data   : lookup request (index)
//   out_valid/out_data : lookup result, one cycle later
module lut_neuron_cfg_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                table_ready,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int DEPTH  = 2 ** IN_BITS;
    localparam int TBITS  = DEPTH * OUT_BITS;
    localparam int NBEATS = (TBITS + CFG_W - 1) / CFG_W;
    localparam int CW     = $clog2(NBEATS + 1);
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            done_n;
    logic            err_n;
    logic            accept;
    logic            lookup;
    logic [TBITS-1:0] tbl;
    logic [DEPTH-1:0][OUT_BITS-1:0] entries;

    assign cfg_ready   = (state == LOAD);
    assign table_ready = (state == ARMED);
    // A restart in the same cycle as a beat wins; the beat is dropped.
    assign accept      = cfg_valid & cfg_ready & ~cfg_start;
    assign lookup      = in_valid & table_ready;
    assign entries     = tbl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cfg_done <= done_n;
            cfg_err  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    err_n = 1'b1;
                    cnt_n = '0;
                end else if (accept) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST) begin
                        done_n  = 1'b1;
                        state_n = ARMED;
                    end
                end
            end
            ARMED: begin
                if (cfg_start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Each table bit knows statically which beat and lane feed it, so
    // padding bits of the final beat simply have no destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl <= '0;
        end else if (accept) begin
            for (int b = 0; b < TBITS; b++) begin
                if (cnt == CW'(b / CFG_W)) begin
                    tbl[b] <= cfg_data[b % CFG_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= lookup;
            if (lookup) begin
                out_data <= entries[in_data];
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_cfg_loader.sv
// Directed bench for lut_neuron_cfg_loader with a behavioural
// table/FSM model and a lookup scoreboard queue.
module tb_lut_neuron_cfg_loader;

    logic       clk;
    logic       rst;
    logic       cfg_start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic       table_ready;
    logic       in_valid;
    logic [5:0] in_data;
    logic       out_valid;
    logic [0:0] out_data;

    lut_neuron_cfg_loader dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .table_ready (table_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { S_IDLE, S_LOAD, S_ARMED } mstate_t;

    int          vectors;
    int          miscompares;
    mstate_t     st;
    int          cnt;
    logic [63:0] mtbl;
    logic        last_d;
    logic [1:0]  sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic       v;
        logic       d;
        logic       e_done;
        logic       e_err;
        logic [1:0] e;
        chk("cfg_ready", 32'(cfg_ready), 32'(st == S_LOAD));
        v = in_valid && (st == S_ARMED);
        d = v ? mtbl[in_data] : last_d;
        last_d = d;
        sb.push_back({v, d});
        e_done = 1'b0;
        e_err  = 1'b0;
        case (st)
            S_IDLE: if (cfg_start) begin
                st  = S_LOAD;
                cnt = 0;
            end
            S_LOAD: if (cfg_start) begin
                e_err = 1'b1;
                cnt   = 0;
            end else if (cfg_valid) begin
                for (int j = 0; j < 8; j++)
                    mtbl[6'(cnt * 8 + j)] = cfg_data[j];
                cnt++;
                if (cnt == 8) begin
                    e_done = 1'b1;
                    st     = S_ARMED;
                end
            end
            default: if (cfg_start) begin
                st  = S_LOAD;
                cnt = 0;
            end
        endcase
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e[1]));
        chk("out_data", 32'(out_data), 32'(e[0]));
        chk("cfg_done", 32'(cfg_done), 32'(e_done));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));
        chk("table_ready", 32'(table_ready), 32'(st == S_ARMED));
    endtask

    task automatic start(input logic with_beat);
        cfg_start = 1'b1;
        cfg_valid = with_beat;
        cfg_data  = 8'h5A;
        cyc();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic beat(input logic [7:0] b);
        cfg_valid = 1'b1;
        cfg_data  = b;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic sweep();
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 6'(i);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic model_reset();
        st     = S_IDLE;
        cnt    = 0;
        mtbl   = '0;
        last_d = 1'b0;
        sb.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, "_done"}, 32'(cfg_done), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_tready"}, 32'(table_ready), 32'd0);
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, "_odata"}, 32'(out_data), 32'd0);
    endtask

    logic [7:0] pat[8];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        in_valid  = 1'b1;
        in_data   = 6'd5;
        model_reset();
        #1;
        chk_all_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle: lookups and stray beats ignored.
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        repeat (3) cyc();
        cfg_valid = 1'b0;
        in_valid  = 1'b0;

        // First load: only bits 5 and 7 set.
        start(1'b0);
        beat(8'hA0);
        for (int k = 1; k < 8; k++) beat(8'h00);
        in_valid = 1'b1;
        in_data  = 6'd5;
        cyc();
        chk("lut5", 32'(out_data), 32'd1);
        in_data = 6'd7;
        cyc();
        chk("lut7", 32'(out_data), 32'd1);
        in_data = 6'd6;
        cyc();
        chk("lut6", 32'(out_data), 32'd0);
        chk("lut6_v", 32'(out_valid), 32'd1);

        // Reload all-ones while lookups keep streaming.
        in_data = 6'(5);
        start(1'b0);
        for (int k = 0; k < 8; k++) begin
            in_data = 6'($urandom);
            beat(8'hFF);
        end
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 6'(i);
            cyc();
            chk("ones", 32'(out_data), 32'd1);
        end
        in_valid = 1'b0;

        // Restart after three beats, with a beat in the restart cycle.
        start(1'b0);
        for (int k = 0; k < 3; k++) beat(8'($urandom));
        start(1'b1);
        for (int k = 0; k < 8; k++) pat[k] = 8'($urandom);
        for (int k = 0; k < 8; k++) beat(pat[k]);
        chk("restart_pat", 32'(mtbl[31:0]),
            {pat[3], pat[2], pat[1], pat[0]});
        sweep();

        // cfg_valid held in ARMED without cfg_start: nothing taken.
        cfg_valid = 1'b1;
        cfg_data  = 8'h00;
        repeat (5) cyc();
        cfg_valid = 1'b0;
        sweep();

        // Asynchronous reset in the middle of a load.
        start(1'b0);
        for (int k = 0; k < 4; k++) beat(8'hC3);
        cfg_valid = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        chk_all_zero("midrst2");
        rst       = 1'b0;
        cfg_valid = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 6'(i * 5);
            cyc();
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
